// File: rtl/array_bank_loader_if.sv
// Sample stream in, bank group out.
// One valid/ready handshake on each side.
interface array_bank_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] fill_cnt;
  logic [7:0] bank0, bank1, bank2, bank3;
  logic [7:0] bank4, bank5, bank6, bank7;
  logic [7:0] bank8, bank9, bank10, bank11;
  logic [7:0] bank12, bank13, bank14, bank15;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, fill_cnt,
    output bank0, bank1, bank2, bank3,
    output bank4, bank5, bank6, bank7,
    output bank8, bank9, bank10, bank11,
    output bank12, bank13, bank14, bank15
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, fill_cnt,
    input  bank0, bank1, bank2, bank3,
    input  bank4, bank5, bank6, bank7,
    input  bank8, bank9, bank10, bank11,
    input  bank12, bank13, bank14, bank15
  );
endinterface

// File: rtl/array_bank_loader.sv
// Deserializes 8-bit samples into 16 bank registers
// and hands the full group to the adder tree.
module array_bank_loader #(
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  array_bank_loader_if.slave b
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t     state;
  logic [3:0] idx;
  logic [4:0] cnt;
  logic       valid;
  logic [7:0] bank [16];

  // Ready depends only on state and reset, never on in_valid.
  assign b.in_ready  = (state == FILL) && !rst;
  assign b.out_valid = valid;
  assign b.fill_cnt  = cnt;

  assign b.bank0  = bank[0];
  assign b.bank1  = bank[1];
  assign b.bank2  = bank[2];
  assign b.bank3  = bank[3];
  assign b.bank4  = bank[4];
  assign b.bank5  = bank[5];
  assign b.bank6  = bank[6];
  assign b.bank7  = bank[7];
  assign b.bank8  = bank[8];
  assign b.bank9  = bank[9];
  assign b.bank10 = bank[10];
  assign b.bank11 = bank[11];
  assign b.bank12 = bank[12];
  assign b.bank13 = bank[13];
  assign b.bank14 = bank[14];
  assign b.bank15 = bank[15];

  // Fill/hold sequencer: reset, then abort, then handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      for (int i = 0; i < 16; i++)
        bank[i] <= '0;
    end else if (abort) begin
      state <= FILL;
      idx   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (b.in_valid) begin
            bank[idx] <= b.in_data;
            idx       <= idx + 4'd1;
            cnt       <= cnt + 5'd1;
            if (idx == 4'd15 || b.in_last) begin
              state <= HOLD;
              valid <= 1'b1;
              if (ZERO_FILL) begin
                for (int i = 0; i < 16; i++)
                  if (i > int'(idx))
                    bank[i] <= '0;
              end
            end
          end
        end
        HOLD: begin
          if (b.out_ready) begin
            state <= FILL;
            idx   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
